// File: rtl/addsub_serial.sv
// addsub_serial
//   Digit-serial add/subtract unit. Operands are WIDTH bits wide and are
//   processed DIGIT bits per clock with a registered carry between digits,
//   so no full-width ripple path exists. A start/busy/done handshake frames
//   each operation; results and flags change only when an operation completes.
//
//   Ports
//     clk       rising-edge clock
//     rst_n     asynchronous active-low reset
//     start     operation request, sampled only when idle
//     Mode      0 = add, 1 = subtract
//     A, B      operands (A is minuend for subtract)
//     CarryIN   carry-in (add) / borrow-in (subtract)
//     busy      high whenever an operation is in flight
//     done      one-cycle pulse, results valid
//     Y         result
//     CarryOUT  carry-out (add) / borrow-out (subtract)
//     Overflow  two's-complement signed overflow
//     Zero      Y == 0
//
//   Parameters: WIDTH >= 2, DIGIT must divide WIDTH.
//
//   state  | meaning
//   -------+-------------------------------------------------
//   IDLE   | waiting for start; operands latched on accept
//   RUN    | one digit per cycle, digit index k = 0..NDIG-1
//   DONE   | results valid, done asserted for this cycle
module addsub_serial #(
   parameter int WIDTH = 16,
   parameter int DIGIT = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             Mode,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic             CarryIN,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] Y,
   output logic             CarryOUT,
   output logic             Overflow,
   output logic             Zero
);

   localparam int NDIG = WIDTH / DIGIT;
   localparam int KW   = (NDIG > 1) ? $clog2(NDIG) : 1;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t r_state;
   state_t w_state_next;

   // r_a doubles as the result shift register: each cycle the low operand
   // digit is consumed and the new sum digit enters at the top, so after
   // NDIG digits it holds the complete result with digit 0 at the bottom.
   logic [WIDTH-1:0]       r_a;
   logic [WIDTH-1:0]       r_b;
   logic                   r_mode;
   logic                   r_carry;
   logic                   r_a_msb;
   logic                   r_b_msb;   // MSB of the effective (possibly inverted) B
   logic [KW-1:0]          r_k;

   logic [DIGIT:0]         w_sum;
   logic [WIDTH+DIGIT-1:0] w_cat;
   logic [WIDTH-1:0]       w_shift;
   logic                   w_last;
   logic                   w_ovf;

   assign w_sum   = {1'b0, r_a[DIGIT-1:0]} + {1'b0, r_b[DIGIT-1:0]} + {{DIGIT{1'b0}}, r_carry};
   assign w_cat   = {w_sum[DIGIT-1:0], r_a};
   assign w_shift = w_cat[WIDTH+DIGIT-1:DIGIT];
   assign w_last  = (r_k == KW'(NDIG - 1));

   // Subtract is A + ~B, so "effective operand MSBs equal and result MSB
   // differs from A" covers both the add and subtract overflow rules.
   assign w_ovf   = (r_a_msb == r_b_msb) && (w_shift[WIDTH-1] != r_a_msb);

   assign busy = (r_state != S_IDLE);
   assign done = (r_state == S_DONE);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   always_comb begin
      w_state_next = r_state;
      case (r_state)
         S_IDLE:  if (start) w_state_next = S_RUN;
         S_RUN:   if (w_last) w_state_next = S_DONE;
         S_DONE:  w_state_next = S_IDLE;
         default: w_state_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_a      <= '0;
         r_b      <= '0;
         r_mode   <= 1'b0;
         r_carry  <= 1'b0;
         r_a_msb  <= 1'b0;
         r_b_msb  <= 1'b0;
         r_k      <= '0;
         Y        <= '0;
         CarryOUT <= 1'b0;
         Overflow <= 1'b0;
         Zero     <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (start) begin
                  r_a     <= A;
                  r_b     <= Mode ? ~B : B;
                  r_mode  <= Mode;
                  r_carry <= Mode ^ CarryIN;
                  r_a_msb <= A[WIDTH-1];
                  r_b_msb <= Mode ^ B[WIDTH-1];
                  r_k     <= '0;
               end
            end
            S_RUN: begin
               r_a     <= w_shift;
               r_b     <= r_b >> DIGIT;
               r_carry <= w_sum[DIGIT];
               r_k     <= r_k + 1'b1;
               if (w_last) begin
                  Y        <= w_shift;
                  CarryOUT <= r_mode ^ w_sum[DIGIT];
                  Overflow <= w_ovf;
                  Zero     <= (w_shift == '0);
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_addsub_serial.sv
module tb_addsub_serial;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst_n;

   logic        s16, m16, ci16, busy16, done16, co16, ov16, z16;
   logic [15:0] a16, b16, y16;
   logic        s4, m4, ci4, busy4, done4, co4, ov4, z4;
   logic [3:0]  a4, b4, y4;
   logic        s8, m8, ci8, busy8, done8, co8, ov8, z8;
   logic [7:0]  a8, b8, y8;

   int n_tests = 0;
   int n_fail  = 0;

   addsub_serial #(.WIDTH(16), .DIGIT(4)) u_dut16 (
      .clk(clk), .rst_n(rst_n), .start(s16), .Mode(m16), .A(a16), .B(b16), .CarryIN(ci16),
      .busy(busy16), .done(done16), .Y(y16), .CarryOUT(co16), .Overflow(ov16), .Zero(z16));

   addsub_serial #(.WIDTH(4), .DIGIT(1)) u_dut4 (
      .clk(clk), .rst_n(rst_n), .start(s4), .Mode(m4), .A(a4), .B(b4), .CarryIN(ci4),
      .busy(busy4), .done(done4), .Y(y4), .CarryOUT(co4), .Overflow(ov4), .Zero(z4));

   addsub_serial #(.WIDTH(8), .DIGIT(8)) u_dut8 (
      .clk(clk), .rst_n(rst_n), .start(s8), .Mode(m8), .A(a8), .B(b8), .CarryIN(ci8),
      .busy(busy8), .done(done8), .Y(y8), .CarryOUT(co8), .Overflow(ov8), .Zero(z8));

   // Runs one operation; lat = edges from accept to done, bc = cycles busy,
   // nd = done pulses seen. A timeout leaves lat at -1.
   task automatic run16(input logic m, input logic [15:0] av, input logic [15:0] bv,
                        input logic ci, output int lat, output int bc, output int nd);
      @(negedge clk);
      m16 = m; a16 = av; b16 = bv; ci16 = ci; s16 = 1'b1;
      lat = -1; bc = 0; nd = 0;
      for (int n = 1; n <= 20; n++) begin
         @(negedge clk);
         s16 = 1'b0;
         if (busy16) bc++;
         if (done16) begin
            nd++;
            if (lat < 0) lat = n - 1;
         end
         if (!busy16) break;
      end
   endtask

   task automatic run4(input logic m, input logic [3:0] av, input logic [3:0] bv,
                       input logic ci, output int lat, output int nd);
      @(negedge clk);
      m4 = m; a4 = av; b4 = bv; ci4 = ci; s4 = 1'b1;
      lat = -1; nd = 0;
      for (int n = 1; n <= 20; n++) begin
         @(negedge clk);
         s4 = 1'b0;
         if (done4) begin
            nd++;
            if (lat < 0) lat = n - 1;
         end
         if (!busy4) break;
      end
   endtask

   task automatic run8(input logic m, input logic [7:0] av, input logic [7:0] bv,
                       input logic ci, output int lat, output int bc, output int nd);
      @(negedge clk);
      m8 = m; a8 = av; b8 = bv; ci8 = ci; s8 = 1'b1;
      lat = -1; bc = 0; nd = 0;
      for (int n = 1; n <= 20; n++) begin
         @(negedge clk);
         s8 = 1'b0;
         if (busy8) bc++;
         if (done8) begin
            nd++;
            if (lat < 0) lat = n - 1;
         end
         if (!busy8) break;
      end
   endtask

   task automatic test_reset;
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      n_tests++; if (y16 !== 16'h0000) begin n_fail++; $display("FAIL reset_y16 got=%h exp=0000", y16); end
      n_tests++; if ({busy16, done16, co16, ov16, z16} !== 5'b0) begin n_fail++; $display("FAIL reset_flags16 got=%b exp=00000", {busy16, done16, co16, ov16, z16}); end
      n_tests++; if ({y4, busy4, done4, co4, ov4, z4} !== 9'b0) begin n_fail++; $display("FAIL reset_dut4 got=%b exp=0", {y4, busy4, done4, co4, ov4, z4}); end
      n_tests++; if ({y8, busy8, done8, co8, ov8, z8} !== 13'b0) begin n_fail++; $display("FAIL reset_dut8 got=%b exp=0", {y8, busy8, done8, co8, ov8, z8}); end
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_sub_borrow;
      int lat, bc, nd;
      run16(1'b1, 16'h0001, 16'h0002, 1'b0, lat, bc, nd);
      n_tests++; if (y16 !== 16'hFFFF) begin n_fail++; $display("FAIL sub_borrow_y got=%h exp=FFFF", y16); end
      n_tests++; if ({co16, ov16, z16} !== 3'b100) begin n_fail++; $display("FAIL sub_borrow_flags got=%b exp=100", {co16, ov16, z16}); end
      n_tests++; if (lat !== 4) begin n_fail++; $display("FAIL sub_borrow_latency got=%0d exp=4", lat); end
      n_tests++; if (bc !== 5) begin n_fail++; $display("FAIL sub_borrow_busy_cycles got=%0d exp=5", bc); end
      n_tests++; if (nd !== 1) begin n_fail++; $display("FAIL sub_borrow_done_count got=%0d exp=1", nd); end
   endtask

   task automatic test_overflow;
      int lat, bc, nd;
      run16(1'b0, 16'h7FFF, 16'h0001, 1'b0, lat, bc, nd);
      n_tests++; if (y16 !== 16'h8000) begin n_fail++; $display("FAIL add_ovf_y got=%h exp=8000", y16); end
      n_tests++; if ({co16, ov16, z16} !== 3'b010) begin n_fail++; $display("FAIL add_ovf_flags got=%b exp=010", {co16, ov16, z16}); end
      run16(1'b1, 16'h8000, 16'h0001, 1'b0, lat, bc, nd);
      n_tests++; if (y16 !== 16'h7FFF) begin n_fail++; $display("FAIL sub_ovf_y got=%h exp=7FFF", y16); end
      n_tests++; if ({co16, ov16, z16} !== 3'b010) begin n_fail++; $display("FAIL sub_ovf_flags got=%b exp=010", {co16, ov16, z16}); end
   endtask

   task automatic test_carry_ripple;
      int lat, bc, nd;
      run16(1'b0, 16'hFFFF, 16'h0000, 1'b1, lat, bc, nd);
      n_tests++; if (y16 !== 16'h0000) begin n_fail++; $display("FAIL ripple_y got=%h exp=0000", y16); end
      n_tests++; if ({co16, ov16, z16} !== 3'b101) begin n_fail++; $display("FAIL ripple_flags got=%b exp=101", {co16, ov16, z16}); end
      run16(1'b1, 16'h0005, 16'h0003, 1'b1, lat, bc, nd);
      n_tests++; if (y16 !== 16'h0001) begin n_fail++; $display("FAIL borrow_in_y got=%h exp=0001", y16); end
      n_tests++; if ({co16, ov16, z16} !== 3'b000) begin n_fail++; $display("FAIL borrow_in_flags got=%b exp=000", {co16, ov16, z16}); end
   endtask

   // Previous result is 0x0001 from test_carry_ripple.
   task automatic test_ignore_inputs;
      int nd, done_at, bad_y;
      @(negedge clk);
      m16 = 1'b0; a16 = 16'h1234; b16 = 16'h1111; ci16 = 1'b0; s16 = 1'b1;
      nd = 0; done_at = -1; bad_y = 0;
      for (int n = 1; n <= 12; n++) begin
         @(negedge clk);
         case (n)
            1: s16 = 1'b0;
            2: begin s16 = 1'b1; m16 = 1'b1; a16 = 16'hFFFF; b16 = 16'h0AAA; ci16 = 1'b1; end
            3: s16 = 1'b0;
            5: begin s16 = 1'b1; a16 = 16'h5555; end
            6: s16 = 1'b0;
            default: ;
         endcase
         if (n < 5 && y16 !== 16'h0001) bad_y++;
         if (done16) begin
            nd++;
            if (done_at < 0) done_at = n;
         end
      end
      n_tests++; if (bad_y !== 0) begin n_fail++; $display("FAIL ignore_y_held got=%0d early changes exp=0", bad_y); end
      n_tests++; if (nd !== 1) begin n_fail++; $display("FAIL ignore_done_count got=%0d exp=1", nd); end
      n_tests++; if (done_at !== 5) begin n_fail++; $display("FAIL ignore_done_time got=%0d exp=5", done_at); end
      n_tests++; if (y16 !== 16'h2345) begin n_fail++; $display("FAIL ignore_y got=%h exp=2345", y16); end
      n_tests++; if (busy16 !== 1'b0) begin n_fail++; $display("FAIL ignore_no_extra_op busy=%b exp=0", busy16); end
   endtask

   task automatic test_back_to_back;
      int nd, d1, d2;
      @(negedge clk);
      m16 = 1'b0; a16 = 16'h0010; b16 = 16'h0020; ci16 = 1'b0; s16 = 1'b1;
      nd = 0; d1 = -1; d2 = -1;
      for (int n = 1; n <= 16; n++) begin
         @(negedge clk);
         if (n == 12) s16 = 1'b0;
         if (done16) begin
            nd++;
            if (d1 < 0) d1 = n;
            else if (d2 < 0) d2 = n;
         end
      end
      n_tests++; if (nd !== 2) begin n_fail++; $display("FAIL b2b_done_count got=%0d exp=2", nd); end
      n_tests++; if (d1 !== 5) begin n_fail++; $display("FAIL b2b_first_done got=%0d exp=5", d1); end
      n_tests++; if (d2 - d1 !== 6) begin n_fail++; $display("FAIL b2b_period got=%0d exp=6", d2 - d1); end
      n_tests++; if (y16 !== 16'h0030) begin n_fail++; $display("FAIL b2b_y got=%h exp=0030", y16); end
   endtask

   task automatic test_reset_mid_run;
      int nd, lat, bc;
      // Make Y and flags non-zero first so the reset clearing them is visible.
      run16(1'b1, 16'h0001, 16'h0002, 1'b0, lat, bc, nd);
      @(negedge clk);
      m16 = 1'b0; a16 = 16'h0F0F; b16 = 16'h0101; ci16 = 1'b0; s16 = 1'b1;
      @(negedge clk);
      s16 = 1'b0;
      @(negedge clk);
      @(posedge clk);
      rst_n = 1'b0;
      #1;
      n_tests++; if (y16 !== 16'h0000) begin n_fail++; $display("FAIL midreset_y got=%h exp=0000", y16); end
      n_tests++; if ({busy16, done16, co16, ov16, z16} !== 5'b0) begin n_fail++; $display("FAIL midreset_flags got=%b exp=00000", {busy16, done16, co16, ov16, z16}); end
      @(negedge clk);
      rst_n = 1'b1;
      nd = 0;
      for (int n = 0; n < 8; n++) begin
         @(negedge clk);
         if (done16 || busy16) nd++;
      end
      n_tests++; if (nd !== 0) begin n_fail++; $display("FAIL midreset_no_done got=%0d active cycles exp=0", nd); end
      run16(1'b1, 16'h1000, 16'h0001, 1'b0, lat, bc, nd);
      n_tests++; if (y16 !== 16'h0FFF) begin n_fail++; $display("FAIL after_reset_y got=%h exp=0FFF", y16); end
      n_tests++; if ({co16, ov16, z16} !== 3'b000) begin n_fail++; $display("FAIL after_reset_flags got=%b exp=000", {co16, ov16, z16}); end
      n_tests++; if (lat !== 4) begin n_fail++; $display("FAIL after_reset_latency got=%0d exp=4", lat); end
   endtask

   task automatic test_small_widths;
      int lat, bc, nd;
      run4(1'b1, 4'h8, 4'hC, 1'b0, lat, nd);
      n_tests++; if (y4 !== 4'hC) begin n_fail++; $display("FAIL w4_y got=%h exp=c", y4); end
      n_tests++; if ({co4, ov4, z4} !== 3'b100) begin n_fail++; $display("FAIL w4_flags got=%b exp=100", {co4, ov4, z4}); end
      n_tests++; if (lat !== 4) begin n_fail++; $display("FAIL w4_latency got=%0d exp=4", lat); end
      run8(1'b0, 8'h80, 8'h80, 1'b0, lat, bc, nd);
      n_tests++; if (y8 !== 8'h00) begin n_fail++; $display("FAIL w8_y got=%h exp=00", y8); end
      n_tests++; if ({co8, ov8, z8} !== 3'b111) begin n_fail++; $display("FAIL w8_flags got=%b exp=111", {co8, ov8, z8}); end
      n_tests++; if (lat !== 1) begin n_fail++; $display("FAIL w8_latency got=%0d exp=1", lat); end
      n_tests++; if (bc !== 2) begin n_fail++; $display("FAIL w8_busy_cycles got=%0d exp=2", bc); end
      n_tests++; if (nd !== 1) begin n_fail++; $display("FAIL w8_done_count got=%0d exp=1", nd); end
   endtask

   initial begin
      s16 = 1'b0; m16 = 1'b0; a16 = '0; b16 = '0; ci16 = 1'b0;
      s4  = 1'b0; m4  = 1'b0; a4  = '0; b4  = '0; ci4  = 1'b0;
      s8  = 1'b0; m8  = 1'b0; a8  = '0; b8  = '0; ci8  = 1'b0;
      test_reset();
      test_sub_borrow();
      test_overflow();
      test_carry_ripple();
      test_ignore_inputs();
      test_back_to_back();
      test_reset_mid_run();
      test_small_widths();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog timeout at %0t", $time);
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/addsub_serial.md
# addsub_serial

Parametrised, multi-cycle add/subtract unit that processes WIDTH-bit operands DIGIT bits per clock with a registered carry/borrow chain between digits. A start/busy/done handshake replaces the purely combinational 4-bit subtractor for wide datapaths where a full-width ripple does not close timing. It also adds an add mode and signed-overflow and zero flags. It sits in the arithmetic datapath alongside the existing subtraction unit, and its CarryIN/CarryOUT conventions match that unit.

## Interface
- WIDTH, 16: operand/result width in bits; ≥ 2.
- DIGIT, 4: bits processed per cycle. Must divide WIDTH. NDIG = WIDTH/DIGIT.
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  request; sampled only in IDLE.
- Mode  in  1  0 = add, 1 = subtract.
- A  in  WIDTH  minuend / addend.
- B  in  WIDTH  subtrahend / addend.
- CarryIN  in  1  carry-in (add) or borrow-in (subtract).
- busy  out  1  high whenever state ≠ IDLE.
- done  out  1  one-cycle pulse; results valid.
- Y  out  WIDTH  result.
- CarryOUT  out  1  carry-out (add) or borrow-out (subtract).
- Overflow  out  1  two's-complement signed overflow of the operation.
- Zero  out  1  Y == 0.

## Operation
- Add: {CarryOUT, Y} = A + B + CarryIN.
- Subtract: Y = (A − B − CarryIN) mod 2^WIDTH.
  - CarryOUT = 1 iff A < B + CarryIN (unsigned borrow).
  - Implementation: A + ~B + ~CarryIN. Borrow-out is the inverted final carry.
- Overflow:
  - Add: operand MSBs equal and Y MSB differs.
  - Subtract: A and B MSBs differ and Y MSB differs from A's.
- FSM states: IDLE, RUN, DONE.
  - IDLE → RUN when start = 1. On this edge, latch A, B (pre-inverted if Mode = 1), Mode and the initial carry into internal registers, and set digit index k = 0.
  - RUN: each cycle adds digit k of the latched operands plus the registered carry. It writes the sum digit into an internal result shift register, registers the new carry and increments k. When k = NDIG−1 → DONE.
  - DONE → IDLE unconditionally.
- Y, CarryOUT, Overflow and Zero update only on the edge that enters DONE. They hold stable until the next operation completes, so no partial digits ever appear on Y.
- start is ignored while busy. A, B, Mode and CarryIN changes after acceptance are ignored.
- Reset (rst_n low, any time including mid-RUN):
  - state = IDLE.
  - busy = done = 0, Y = 0, CarryOUT = Overflow = 0, Zero = 0.
  - All internal registers cleared. An aborted operation produces no done.

## Timing
- E0 = edge sampling start = 1 in IDLE. busy rises after E0.
- Edges E1..ENDIG process digits 0..NDIG−1. At ENDIG, outputs are registered and state = DONE.
- done is high for exactly the one cycle between ENDIG and ENDIG+1, decoded from state. busy falls after ENDIG+1.
- Latency from start edge to done: NDIG cycles. Throughput: one operation per NDIG+2 cycles.
- A start held high continuously is accepted at ENDIG+2, the first IDLE edge.
- NDIG = 1 (DIGIT = WIDTH) is legal: one RUN cycle, same state sequence.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Test plan
Cases 1–5 use WIDTH = 16, DIGIT = 4.

1. Subtract A = 0x0001, B = 0x0002, CarryIN = 0
   → done 4 cycles after start; Y = 0xFFFF, CarryOUT = 1, Overflow = 0, Zero = 0. busy high for 5 cycles.
2. Add A = 0x7FFF, B = 0x0001, CarryIN = 0 → Y = 0x8000, CarryOUT = 0, Overflow = 1.
   - Subtract A = 0x8000, B = 0x0001, CarryIN = 0 → Y = 0x7FFF, CarryOUT = 0, Overflow = 1.
3. Add A = 0xFFFF, B = 0x0000, CarryIN = 1 → Y = 0x0000, CarryOUT = 1, Zero = 1 (carry ripples through all four digits).
   - Subtract A = 0x0005, B = 0x0003, CarryIN = 1 → Y = 0x0001, CarryOUT = 0.
4. Start op 1, then pulse start and change A/B/Mode during RUN and during DONE
   → result still that of op 1, a single done, previous Y unchanged until that done.
5. Assert rst_n = 0 at E2 of an operation
   → Y = 0, all flags 0, busy = 0 immediately, no done.
   - Then a fresh subtract A = 0x1000, B = 0x0001 → Y = 0x0FFF, CarryOUT = 0.
6. WIDTH = 4, DIGIT = 1 (NDIG = 4): subtract A = 0x8, B = 0xC, CarryIN = 0 → Y = 0xC, CarryOUT = 1, Overflow = 0.
   - WIDTH = 8, DIGIT = 8: add A = 0x80, B = 0x80 → Y = 0x00, CarryOUT = 1, Overflow = 1, Zero = 1, done 1 cycle after start.
